// File: rtl/rpn_calc_sequencer.sv
// Drives an RPN calculator through one full load-A / load-B / load-Op / acknowledge
// cycle per request, then returns the displayed result and flags (or a timeout).
module rpn_calc_sequencer #(
  parameter int         HOLD_CYCLES    = 16,
  parameter int         GAP_CYCLES     = 8,
  parameter int         TIMEOUT_CYCLES = 64,
  parameter logic [2:0] ST_LOAD_A      = 3'd1,
  parameter logic [2:0] ST_LOAD_B      = 3'd2,
  parameter logic [2:0] ST_LOAD_OP     = 3'd3,
  parameter logic [2:0] ST_SHOW        = 3'd4
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [1:0]  req_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic        rsp_timeout,
  output logic        calc_enter,
  output logic [15:0] calc_datain,
  input  logic [15:0] calc_todisplay,
  input  logic [3:0]  calc_flags,
  input  logic [2:0]  calc_status
);

  typedef enum logic [2:0] {S_IDLE, S_PRESS, S_GAP, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {PH_A, PH_B, PH_OP, PH_ACK} phase_t;

  // Zero-valued parameters behave as 1; oversized ones clamp to the 16-bit counter range.
  localparam int HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : ((HOLD_CYCLES > 65535) ? 65535 : HOLD_CYCLES);
  localparam int GAP_EFF  = (GAP_CYCLES < 1) ? 1 : ((GAP_CYCLES > 65535) ? 65535 : GAP_CYCLES);
  localparam int TO_EFF   = (TIMEOUT_CYCLES < 1) ? 1 : ((TIMEOUT_CYCLES > 65535) ? 65535 : TIMEOUT_CYCLES);

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_EFF - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_EFF - 1);
  localparam logic [15:0] TO_LIMIT  = 16'(TO_EFF);

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] datain_q, datain_d;
  logic [15:0] result_q, result_d;
  logic [3:0]  flags_q, flags_d;
  logic        timeout_q, timeout_d;

  logic [15:0] cntInc;
  logic [2:0]  expStatus;

  assign cntInc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    expStatus = ST_LOAD_A;
    case (phase_q)
      PH_A:    expStatus = ST_LOAD_B;
      PH_B:    expStatus = ST_LOAD_OP;
      PH_OP:   expStatus = ST_SHOW;
      default: expStatus = ST_LOAD_A;
    endcase
  end

  assign req_ready   = resetN && (state_q == S_IDLE) && (calc_status == ST_LOAD_A) && !rsp_valid;
  assign rsp_valid   = (state_q == S_RESP);
  assign calc_enter  = (state_q == S_PRESS);
  assign calc_datain = datain_q;
  assign rsp_result  = result_q;
  assign rsp_flags   = flags_q;
  assign rsp_timeout = timeout_q;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    b_d       = b_q;
    op_d      = op_q;
    datain_d  = datain_q;
    result_d  = result_q;
    flags_d   = flags_q;
    timeout_d = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          b_d      = req_b;
          op_d     = req_op;
          datain_d = req_a;
          phase_d  = PH_A;
          cnt_d    = 16'd0;
          state_d  = S_PRESS;
        end
      end

      S_PRESS: begin
        if (cnt_q >= HOLD_LAST) begin
          cnt_d   = 16'd0;
          state_d = S_GAP;
        end else begin
          cnt_d = cntInc;
        end
      end

      S_GAP: begin
        if (cnt_q >= GAP_LAST) begin
          cnt_d   = 16'd0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cntInc;
        end
      end

      // A status match always wins over an expiring timeout in the same cycle.
      S_WAIT: begin
        if (calc_status == expStatus) begin
          cnt_d = 16'd0;
          case (phase_q)
            PH_A: begin
              phase_d  = PH_B;
              datain_d = b_q;
              state_d  = S_PRESS;
            end
            PH_B: begin
              phase_d  = PH_OP;
              datain_d = {14'b0, op_q};
              state_d  = S_PRESS;
            end
            PH_OP: begin
              result_d = calc_todisplay;
              flags_d  = calc_flags;
              phase_d  = PH_ACK;
              datain_d = 16'h0000;
              state_d  = S_PRESS;
            end
            default: begin
              timeout_d = 1'b0;
              state_d   = S_RESP;
            end
          endcase
        end else if (cnt_q >= TO_LIMIT) begin
          timeout_d = 1'b1;
          result_d  = 16'h0000;
          flags_d   = 4'h0;
          cnt_d     = 16'd0;
          state_d   = S_RESP;
        end else begin
          cnt_d = cntInc;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q   <= S_IDLE;
      phase_q   <= PH_A;
      cnt_q     <= 16'd0;
      b_q       <= 16'h0000;
      op_q      <= 2'd0;
      datain_q  <= 16'h0000;
      result_q  <= 16'h0000;
      flags_q   <= 4'h0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      b_q       <= b_d;
      op_q      <= op_d;
      datain_q  <= datain_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_rpn_calc_sequencer.sv
// Self-checking bench for rpn_calc_sequencer with a behavioural RPN calculator attached.
module tb_rpn_calc_sequencer;

  localparam int HOLD    = 16;
  localparam int GAP     = 8;
  localparam int TIMEOUT = 64;
  localparam logic [2:0] ST_LOAD_A  = 3'd1;
  localparam logic [2:0] ST_LOAD_B  = 3'd2;
  localparam logic [2:0] ST_LOAD_OP = 3'd3;
  localparam logic [2:0] ST_SHOW    = 3'd4;

  logic        clk = 1'b0;
  logic        resetN;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [1:0]  req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        rsp_timeout;
  logic        calc_enter;
  logic [15:0] calc_datain;
  logic [15:0] calc_todisplay;
  logic [3:0]  calc_flags;
  logic [2:0]  calc_status;

  int testsRun = 0;
  int testsFailed = 0;
  int cyc = 0;

  rpn_calc_sequencer #(
    .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TIMEOUT),
    .ST_LOAD_A(ST_LOAD_A), .ST_LOAD_B(ST_LOAD_B), .ST_LOAD_OP(ST_LOAD_OP), .ST_SHOW(ST_SHOW)
  ) dut (
    .clk(clk), .resetN(resetN),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout),
    .calc_enter(calc_enter), .calc_datain(calc_datain),
    .calc_todisplay(calc_todisplay), .calc_flags(calc_flags), .calc_status(calc_status)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Arithmetic reference of the calculator: returns {result, N, Z, C, V}.
  function automatic logic [19:0] calcRef(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    logic [16:0] s;
    logic [15:0] r;
    logic        c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      2'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[15:0];
        c = s[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      2'd1: begin
        r = a - b;
        c = (a >= b);
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      2'd2: r = a | b;
      default: r = a & b;
    endcase
    return {r, r[15], (r == 16'h0000), c, v};
  endfunction

  // Behavioural calculator: each debounced press advances its Status.
  logic [2:0]  mStatus;
  logic [15:0] mA, mB, mRes;
  logic [3:0]  mFlg;
  int          hiCnt, reactAt;
  logic        calcReset, calcStuck, ovrEn;
  logic [2:0]  ovrVal;
  logic [19:0] mOut;

  always @(posedge clk) begin
    if (calcReset) begin
      mStatus <= ST_LOAD_A;
      hiCnt   <= 0;
      reactAt <= 4;
    end else if (calc_enter) begin
      hiCnt <= hiCnt + 1;
      if (hiCnt + 1 == reactAt && !calcStuck) begin
        case (mStatus)
          ST_LOAD_A: begin mA <= calc_datain; mStatus <= ST_LOAD_B; end
          ST_LOAD_B: begin mB <= calc_datain; mStatus <= ST_LOAD_OP; end
          ST_LOAD_OP: begin
            mOut     = calcRef(mA, mB, calc_datain[1:0]);
            mRes    <= mOut[19:4];
            mFlg    <= mOut[3:0];
            mStatus <= ST_SHOW;
          end
          default: mStatus <= ST_LOAD_A;
        endcase
      end
    end else begin
      hiCnt   <= 0;
      reactAt <= $urandom_range(12, 1);
    end
  end

  assign calc_status    = ovrEn ? ovrVal : mStatus;
  assign calc_todisplay = calcStuck ? 16'hDEAD : ((mStatus == ST_SHOW) ? mRes : 16'h0000);
  assign calc_flags     = calcStuck ? 4'hF : ((mStatus == ST_SHOW) ? mFlg : 4'h0);

  // Press monitor: measures each Enter pulse and records the data presented with it.
  logic [15:0] pressQ[$];
  int          run = 0;
  logic        prevEnter = 1'b0;
  logic [15:0] lastDin = 16'h0;
  bit          stableErr = 1'b0;
  bit          monIgnore = 1'b0;

  always @(negedge clk) begin
    if (monIgnore) begin
      run = 0;
      prevEnter = 1'b0;
    end else begin
      if (calc_enter) begin
        if (run > 0 && calc_datain !== lastDin) stableErr = 1'b1;
        lastDin = calc_datain;
        run++;
      end else if (prevEnter) begin
        checkOutput("enterHoldLen", run, HOLD);
        pressQ.push_back(lastDin);
        run = 0;
      end
      prevEnter = calc_enter;
    end
  end

  task automatic waitReady(input string tag);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, req_ready, 1'b1);
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                               input bit stuck, input int bp);
    int          n, c0;
    bit          readyErr, bpErr, enterErr;
    logic [19:0] refv;
    logic [15:0] expRes, holdRes;
    logic [3:0]  expFlg, holdFlg;
    logic [15:0] expPress[4];

    calcStuck = stuck;
    waitReady("reqReadyIdle");
    pressQ.delete();
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
    c0 = cyc;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_a = 16'($urandom); req_b = 16'($urandom); req_op = 2'($urandom);

    readyErr = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 1000) begin
      if (req_ready) readyErr = 1'b1;
      @(negedge clk);
      n++;
    end
    checkOutput("rspArrived", rsp_valid, 1'b1);
    checkOutput("reqReadyLowBusy", readyErr, 1'b0);
    checkOutput("reqReadyWithRsp", req_ready, 1'b0);
    if (stuck) checkOutput("timeoutLatency", cyc - c0, HOLD + GAP + TIMEOUT + 2);

    refv   = calcRef(a, b, op);
    expRes = stuck ? 16'h0000 : refv[19:4];
    expFlg = stuck ? 4'h0 : refv[3:0];
    checkOutput("rspResult", rsp_result, expRes);
    checkOutput("rspFlags", rsp_flags, expFlg);
    checkOutput("rspTimeout", rsp_timeout, stuck);

    expPress[0] = a; expPress[1] = b; expPress[2] = {14'b0, op}; expPress[3] = 16'h0000;
    checkOutput("pressCount", pressQ.size(), stuck ? 1 : 4);
    for (int i = 0; i < pressQ.size() && i < 4; i++) checkOutput("pressData", pressQ[i], expPress[i]);

    holdRes = rsp_result; holdFlg = rsp_flags;
    bpErr = 1'b0; enterErr = 1'b0;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_result !== holdRes || rsp_flags !== holdFlg || rsp_timeout !== stuck)
        bpErr = 1'b1;
      if (calc_enter !== 1'b0) enterErr = 1'b1;
    end
    checkOutput("bpStable", bpErr, 1'b0);
    checkOutput("bpNoEnter", enterErr, 1'b0);

    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checkOutput("rspCleared", rsp_valid, 1'b0);
    @(negedge clk);
    checkOutput("reqReadyAfter", req_ready, 1'b1);
    calcStuck = 1'b0;
  endtask

  task automatic statusNotReady();
    @(negedge clk);
    ovrEn = 1'b1; ovrVal = ST_SHOW;
    #1;
    checkOutput("notReadyShow", req_ready, 1'b0);
    req_a = 16'h1234; req_b = 16'h5678; req_op = 2'd0; req_valid = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("ignoredNoEnter", calc_enter, 1'b0);
    ovrVal = ST_LOAD_A;
    #1;
    checkOutput("readySameCycle", req_ready, 1'b1);
    req_valid = 1'b0;
    ovrEn = 1'b0;
  endtask

  task automatic resetMidPress();
    int  n;
    bit  seen;
    waitReady("reqReadyPreReset");
    pressQ.delete();
    req_a = 16'hAAAA; req_b = 16'h5555; req_op = 2'd1; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(calc_enter && mStatus == ST_LOAD_B && pressQ.size() == 1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reachedBPress", calc_enter, 1'b1);
    monIgnore = 1'b1;
    resetN = 1'b0; calcReset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rstEnter", calc_enter, 1'b0);
    checkOutput("rstRspValid", rsp_valid, 1'b0);
    checkOutput("rstDatain", calc_datain, 16'h0000);
    @(negedge clk);
    resetN = 1'b1; calcReset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rsp_valid || calc_enter) seen = 1'b1;
    end
    checkOutput("noRspAfterAbort", seen, 1'b0);
    pressQ.delete();
    monIgnore = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, %0d tests run", testsRun);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    resetN = 1'b0; calcReset = 1'b1; calcStuck = 1'b0;
    ovrEn = 1'b0; ovrVal = ST_LOAD_A;
    req_valid = 1'b0; req_a = 16'h0; req_b = 16'h0; req_op = 2'd0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstReqReady", req_ready, 1'b0);
    checkOutput("rstRspValid0", rsp_valid, 1'b0);
    checkOutput("rstRspResult", rsp_result, 16'h0000);
    checkOutput("rstRspFlags", rsp_flags, 4'h0);
    checkOutput("rstRspTimeout", rsp_timeout, 1'b0);
    checkOutput("rstCalcEnter", calc_enter, 1'b0);
    checkOutput("rstCalcDatain", calc_datain, 16'h0000);
    @(negedge clk);
    resetN = 1'b1; calcReset = 1'b0;

    applyStimulus(16'hFFFF, 16'h0101, 2'd0, 1'b0, 10);
    applyStimulus(16'hFFFF, 16'h0101, 2'd1, 1'b0, 0);
    applyStimulus(16'hFFFF, 16'h0101, 2'd2, 1'b0, 0);
    applyStimulus(16'hFFFF, 16'h0003, 2'd3, 1'b0, 0);
    applyStimulus(16'h7FFF, 16'h0001, 2'd0, 1'b0, 3);
    applyStimulus(16'h0001, 16'h0002, 2'd1, 1'b0, 0);
    applyStimulus(16'h1357, 16'h2468, 2'd0, 1'b1, 10);
    statusNotReady();
    for (int i = 0; i < 16; i++)
      applyStimulus(16'($urandom), 16'($urandom), 2'($urandom), 1'b0, $urandom_range(10, 0));
    resetMidPress();
    applyStimulus(16'h8000, 16'h8000, 2'd0, 1'b0, 2);
    checkOutput("datainStable", stableErr, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
